pll_lock_sequencer: RTL and testbench

Reset/lock controller for a single-output fabric PLL (425 MHz in, 219.140625 MHz out class).
- Drives the PLL reset and qualifies its asynchronous locked flag.
- Retries on lock timeout and recovers on loss of lock.
- Presents one clean `ready` and one `fail` status to downstream reset logic and software.
- Runs on the free-running PLL reference clock, never on the PLL output.

---
 rtl/pll_lock_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Reset/lock controller for a single-output fabric PLL. Runs entirely on the
// free-running reference clock. It pulses the PLL reset, qualifies the
// asynchronous locked flag, and retries on lock timeout. It recovers from
// loss of lock and reports one clean ready and one fail status.
//
// Ports:
//   refclk      in   free-running reference clock (sole clock)
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL locked flag, asynchronous to refclk
//   relock_req  in   single-cycle request to re-run the sequence; only exit
//                    from FAIL
//   pll_rst     out  reset to the PLL (high in RESET_PLL and FAIL)
//   ready       out  PLL output clock valid (READY)
//   fail        out  retries exhausted (FAIL)
//   retry_cnt   out  failed attempts in the current sequence
//   lol_cnt     out  loss-of-lock events seen in READY, saturating at 255
//   state       out  current state encoding, for debug
//   lock_time   out  [PLL_LOCK_SEQ_DBG_EN only] cycles from the most recent
//                    WAIT_LOCK entry to READY entry, saturating at 16'hFFFF
//
// Optional feature macro: PLL_LOCK_SEQ_DBG_EN (adds lock_time).
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic        relock_req,
    output logic        pll_rst,
    output logic        ready,
    output logic        fail,
    output logic [1:0]  retry_cnt,
    output logic [7:0]  lol_cnt,
    output logic [2:0]  state
`ifdef PLL_LOCK_SEQ_DBG_EN
    ,
    output logic [15:0] lock_time
`endif
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       MAX_R    = 3'(MAX_RETRIES);

    // -----------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous locked flag
    // -----------------------------------------------------------------------
    logic sync1_q;
    logic lock_s_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer state
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [1:0]       retry_q, retry_d;
    logic [7:0]       lol_q, lol_d;
    logic             pll_rst_q, ready_q, fail_q;

    logic [2:0] retry_inc;
    logic [1:0] retry_sat;
    logic [7:0] lol_sat;
    logic       tmo_hit;

    // retry_inc is one bit wider so the compare against MAX_RETRIES is exact
    // even when retry_q is already at its saturation value.
    assign retry_inc = {1'b0, retry_q} + 3'd1;
    assign retry_sat = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
    assign lol_sat   = (lol_q == 8'hFF) ? 8'hFF : lol_q + 8'd1;
    assign tmo_hit   = (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        lol_d   = lol_q;

        case (state_q)
            ST_RESET_PLL: begin
                if (relock_req) begin
                    phase_d = '0;
                    tmo_d   = '0;
                end else if (phase_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    phase_d = '0;
                    tmo_d   = '0;
                end else begin
                    phase_d = phase_q + CNT_ONE;
                end
            end

            ST_WAIT_LOCK, ST_STABLE: begin
                if (relock_req) begin
                    state_d = ST_RESET_PLL;
                    phase_d = '0;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    // Timeout is checked before lock so it wins a same-cycle tie.
                    state_d = (retry_inc == MAX_R) ? ST_FAIL : ST_RESET_PLL;
                    retry_d = retry_sat;
                    phase_d = '0;
                    tmo_d   = '0;
                end else begin
                    // Timeout keeps running across STABLE->WAIT_LOCK bounces so
                    // a glitching lock still exhausts the attempt.
                    tmo_d = tmo_q + CNT_ONE;
                    if (state_q == ST_WAIT_LOCK) begin
                        if (lock_s_q) begin
                            state_d = ST_STABLE;
                            phase_d = '0;
                        end
                    end else if (!lock_s_q) begin
                        state_d = ST_WAIT_LOCK;
                        phase_d = '0;
                    end else if (phase_q == STB_LAST) begin
                        state_d = ST_READY;
                        retry_d = 2'd0;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + CNT_ONE;
                    end
                end
            end

            ST_READY: begin
                // Loss of lock takes priority over a simultaneous relock request
                // so the event is still counted.
                if (!lock_s_q) begin
                    state_d = ST_RESET_PLL;
                    lol_d   = lol_sat;
                    phase_d = '0;
                    tmo_d   = '0;
                end else if (relock_req) begin
                    state_d = ST_RESET_PLL;
                    phase_d = '0;
                    tmo_d   = '0;
                end
            end

            ST_FAIL: begin
                if (relock_req) begin
                    state_d = ST_RESET_PLL;
                    retry_d = 2'd0;
                    phase_d = '0;
                    tmo_d   = '0;
                end
            end

            default: begin
                state_d = ST_RESET_PLL;
                phase_d = '0;
                tmo_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they always
    // match the state register without combinational glitches.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET_PLL;
            phase_q   <= '0;
            tmo_q     <= '0;
            retry_q   <= 2'd0;
            lol_q     <= 8'd0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            lol_q     <= lol_d;
            pll_rst_q <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
            ready_q   <= (state_d == ST_READY);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign lol_cnt   = lol_q;
    assign state     = state_q;

`ifdef PLL_LOCK_SEQ_DBG_EN
    // -----------------------------------------------------------------------
    // Lock-time capture: counts from the latest WAIT_LOCK entry and latches
    // the elapsed cycles on READY entry.
    // -----------------------------------------------------------------------
    logic [15:0] dbg_cnt_q;
    logic [15:0] lock_time_q;
    logic        enter_wait;
    logic        enter_ready;

    assign enter_wait  = (state_d == ST_WAIT_LOCK) && (state_q != ST_WAIT_LOCK);
    assign enter_ready = (state_d == ST_READY) && (state_q != ST_READY);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            dbg_cnt_q   <= 16'd0;
            lock_time_q <= 16'd0;
        end else begin
            if (enter_wait) begin
                dbg_cnt_q <= 16'd0;
            end else if (dbg_cnt_q != 16'hFFFF) begin
                dbg_cnt_q <= dbg_cnt_q + 16'd1;
            end
            // The counter holds cycles already elapsed; the entry edge adds one.
            if (enter_ready) begin
                lock_time_q <= (dbg_cnt_q == 16'hFFFF) ? 16'hFFFF : dbg_cnt_q + 16'd1;
            end
        end
    end

    assign lock_time = lock_time_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

    localparam int RST_C = 4;
    localparam int STB_C = 8;
    localparam int TMO_C = 32;
    localparam int MAXR  = 2;

    localparam int M_RESET  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STABLE = 2;
    localparam int M_READY  = 3;
    localparam int M_FAIL   = 4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lol_cnt;
    logic [2:0] state;
`ifdef PLL_LOCK_SEQ_DBG_EN
    logic [15:0] lock_time;
`endif

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_CYCLES          (RST_C),
        .LOCK_STABLE_CYCLES  (STB_C),
        .LOCK_TIMEOUT_CYCLES (TMO_C),
        .MAX_RETRIES         (MAXR),
        .CNT_W               (17)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .lol_cnt    (lol_cnt),
        .state      (state)
`ifdef PLL_LOCK_SEQ_DBG_EN
        ,
        .lock_time  (lock_time)
`endif
    );

    typedef struct {
        int st;
        int retry;
        int lol;
        int lt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: timestamps of the last entries into each phase.
    int m_k     = 0;  // edge index
    int m_mode  = M_RESET;
    int m_enter = 0;  // edge of RESET_PLL entry
    int m_att   = 0;  // edge the current attempt started (WAIT from RESET)
    int m_wlast = 0;  // edge of most recent WAIT_LOCK entry
    int m_stab  = 0;  // edge of STABLE entry
    int m_retry = 0;
    int m_lol   = 0;
    int m_lt    = 0;
    logic m_d1 = 1'b0;
    logic m_d2 = 1'b0;

    // Observations taken at the falling edge, before new inputs are driven.
    logic       o_rst_pll, o_ready, o_fail;
    logic [1:0] o_retry;
    logic [7:0] o_lol;
    logic [2:0] o_state;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic model_step(input logic r, input logic lk, input logic rq);
        logic ls;
        exp_t e;
        m_k++;
        if (r) begin
            m_mode  = M_RESET;
            m_enter = m_k;
            m_retry = 0;
            m_lol   = 0;
            m_lt    = 0;
            m_d1    = 1'b0;
            m_d2    = 1'b0;
        end else begin
            ls   = m_d2;
            m_d2 = m_d1;
            m_d1 = lk;
            case (m_mode)
                M_RESET: begin
                    if (rq) m_enter = m_k;
                    else if (m_k - m_enter == RST_C) begin
                        m_mode  = M_WAIT;
                        m_att   = m_k;
                        m_wlast = m_k;
                    end
                end
                M_WAIT, M_STABLE: begin
                    if (rq) begin
                        m_mode  = M_RESET;
                        m_enter = m_k;
                    end else if (m_k - m_att == TMO_C) begin
                        m_mode  = (m_retry + 1 == MAXR) ? M_FAIL : M_RESET;
                        m_enter = m_k;
                        m_retry = (m_retry < 3) ? m_retry + 1 : 3;
                    end else if (m_mode == M_WAIT) begin
                        if (ls) begin
                            m_mode = M_STABLE;
                            m_stab = m_k;
                        end
                    end else if (!ls) begin
                        m_mode  = M_WAIT;
                        m_wlast = m_k;
                    end else if (m_k - m_stab == STB_C) begin
                        m_mode  = M_READY;
                        m_retry = 0;
                        m_lt    = (m_k - m_wlast > 65535) ? 65535 : m_k - m_wlast;
                    end
                end
                M_READY: begin
                    if (!ls) begin
                        m_lol   = (m_lol < 255) ? m_lol + 1 : 255;
                        m_mode  = M_RESET;
                        m_enter = m_k;
                    end else if (rq) begin
                        m_mode  = M_RESET;
                        m_enter = m_k;
                    end
                end
                M_FAIL: begin
                    if (rq) begin
                        m_retry = 0;
                        m_mode  = M_RESET;
                        m_enter = m_k;
                    end
                end
                default: ;
            endcase
        end
        e.st    = m_mode;
        e.retry = m_retry;
        e.lol   = m_lol;
        e.lt    = m_lt;
        exp_q.push_back(e);
    endtask

    // One reference-clock cycle: observe, drive, and predict the next edge.
    task automatic cyc(input logic r, input logic lk, input logic rq);
        @(negedge refclk);
        o_rst_pll  = pll_rst;
        o_ready    = ready;
        o_fail     = fail;
        o_retry    = retry_cnt;
        o_lol      = lol_cnt;
        o_state    = state;
        rst        = r;
        pll_locked = lk;
        relock_req = rq;
        model_step(r, lk, rq);
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        do begin
            cyc(1'b0, 1'b1, 1'b0);
            n++;
        end while (!o_ready && n < budget);
    endtask

    // Monitor: every edge presents a new output word; pop its prediction.
    always @(posedge refclk) begin
        exp_t e;
        logic [15:0] act_v, exp_v;
        logic        e_rst;
        #1;
        if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            e_rst = (e.st == M_RESET) || (e.st == M_FAIL);
            act_v = {state, pll_rst, ready, fail, retry_cnt, lol_cnt};
            exp_v = {3'(e.st), e_rst, (e.st == M_READY), (e.st == M_FAIL), 2'(e.retry), 8'(e.lol)};
            n_chk++;
            if (act_v == exp_v) n_pass++;
            else $display("FAIL cycle_outputs t=%0t: got st=%0d rst=%0b rdy=%0b fail=%0b retry=%0d lol=%0d, expected st=%0d rst=%0b rdy=%0b fail=%0b retry=%0d lol=%0d",
                          $time, state, pll_rst, ready, fail, retry_cnt, lol_cnt,
                          e.st, e_rst, (e.st == M_READY), (e.st == M_FAIL), e.retry, e.lol);
`ifdef PLL_LOCK_SEQ_DBG_EN
            chk("lock_time", lock_time, e.lt);
`endif
        end
    end

    initial begin
        int j, n, n_hi, run, rdy_seen, t;
        int lows[$];
        int highs[$];
        logic prev, lk_r, r_r, rq_r;

        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("reset_pll_rst", pll_rst, 1);
        chk("reset_ready", ready, 0);
        chk("reset_fail", fail, 0);
        chk("reset_retry", retry_cnt, 0);
        chk("reset_lol", lol_cnt, 0);
        chk("reset_state", state, 0);

        // Scenario 1: lock 5 cycles after pll_rst falls
        cyc(1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end while (o_rst_pll && n < 20);
        chk("s1_pll_rst_fell", o_rst_pll, 0);
        j = 1;
        do begin
            j++;
            cyc(1'b0, (j >= 5), 1'b0);
        end while (!o_ready && j < 60);
        chk_rng("s1_fall_to_ready", j - 1, 14, 16);
        chk("s1_retry", o_retry, 0);
`ifdef PLL_LOCK_SEQ_DBG_EN
        chk_rng("s1_lock_time", lock_time, 14, 16);
`endif

        // Scenario 5: relock request from READY
        cyc(1'b0, 1'b1, 1'b1);
        n_hi = 0;
        n = 0;
        do begin
            cyc(1'b0, 1'b1, 1'b0);
            n++;
            if (o_rst_pll) n_hi++;
        end while ((o_rst_pll || n_hi == 0) && n < 20);
        chk("s5_rst_pulse_len", n_hi, RST_C);
        wait_ready(60);
        chk("s5_ready_again", o_ready, 1);
        chk("s5_lol_unchanged", o_lol, 0);

        // Scenario 4: 300 loss-of-lock events
        for (int it = 0; it < 300; it++) begin
            j = 0;
            do begin
                j++;
                cyc(1'b0, (j > 3), 1'b0);
            end while (o_ready && j < 20);
            chk("s4_ready_fall_delay", j - 1, 3);
            wait_ready(80);
            if (it == 0) chk("s4_lol_first", o_lol, 1);
        end
        chk("s4_ready_after_loop", o_ready, 1);
        chk("s4_lol_saturated", o_lol, 255);

        // Scenario 2: lock never comes -> two attempts, then FAIL
        n = 0;
        do begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end while (!o_rst_pll && n < 10);
        prev = o_rst_pll;
        run  = 1;
        n    = 0;
        do begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
            if (o_rst_pll == prev) run++;
            else begin
                if (prev) highs.push_back(run);
                else lows.push_back(run);
                run  = 1;
                prev = o_rst_pll;
            end
        end while (!o_fail && n < 200);
        chk("s2_low_runs", lows.size(), 2);
        chk("s2_high_runs", highs.size(), 2);
        if (lows.size() >= 2) begin
            chk("s2_wait0_len", lows[0], TMO_C);
            chk("s2_wait1_len", lows[1], TMO_C);
        end
        if (highs.size() >= 2) begin
            chk("s2_pulse0_len", highs[0], RST_C);
            chk("s2_pulse1_len", highs[1], RST_C);
        end
        chk("s2_fail", o_fail, 1);
        chk("s2_pll_rst", o_rst_pll, 1);
        chk("s2_retry", o_retry, 2);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("s2_fail_holds", o_fail, 1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s2_relock_retry", o_retry, 0);
        chk("s2_relock_fail", o_fail, 0);
        chk("s2_relock_pll_rst", o_rst_pll, 1);

        // Scenario 3: lock toggling every 6 cycles never qualifies
        n = 0;
        do begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end while (o_rst_pll && n < 20);
        run      = 1;
        rdy_seen = 0;
        t        = 0;
        do begin
            cyc(1'b0, ((t / 6) % 2 == 0), 1'b0);
            t++;
            if (o_ready) rdy_seen++;
            if (!o_rst_pll) run++;
        end while (!o_rst_pll && t < 100);
        chk("s3_timeout_len", run, TMO_C);
        chk("s3_never_ready", rdy_seen, 0);
        chk("s3_retry", o_retry, 1);

        // Scenario 6: asynchronous reset while STABLE
        n = 0;
        do begin
            cyc(1'b0, 1'b1, 1'b0);
            n++;
        end while (m_mode != M_STABLE && n < 40);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("s6_in_stable", o_state, M_STABLE);
        cyc(1'b1, 1'b1, 1'b0);
        #1;
        chk("s6_pll_rst", pll_rst, 1);
        chk("s6_ready", ready, 0);
        chk("s6_fail", fail, 0);
        chk("s6_retry", retry_cnt, 0);
        chk("s6_lol", lol_cnt, 0);
        chk("s6_state", state, 0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        wait_ready(60);
        chk("s6_restart_ready", o_ready, 1);
        chk("s6_restart_retry", o_retry, 0);

        // Randomised traffic against the model
        lk_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(23) == 0) lk_r = ~lk_r;
            rq_r = ($urandom_range(79) == 0);
            r_r  = ($urandom_range(1499) == 0);
            cyc(r_r, lk_r, rq_r);
        end

        @(posedge refclk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
